// File: rtl/display_pkg.sv
// display_pkg: shared FSM state type and BCD constants
// for the serial BCD display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT,
    GAP
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic logic [3:0] clean_digit(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BLANK_CODE : d;
  endfunction

endpackage

// File: rtl/bcd_serial_display_if.sv
// bcd_serial_display_if: bundle of the display data, request
// and status signals; master drives digits/start, slave drives the line.
interface bcd_serial_display_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] value_bcd;
  logic                start;
  logic                value;
  logic                enable;
  logic                board_clk;
  logic                data_clk;
  logic                busy;
  logic                frame_done;
  logic                bcd_err;

  modport master (
    output value_bcd,
    output start,
    input  value,
    input  enable,
    input  board_clk,
    input  data_clk,
    input  busy,
    input  frame_done,
    input  bcd_err
  );

  modport slave (
    input  value_bcd,
    input  start,
    output value,
    output enable,
    output board_clk,
    output data_clk,
    output busy,
    output frame_done,
    output bcd_err
  );

endinterface

// File: rtl/clk_divider.sv
// clk_divider: square-wave divider, toggles clk_out every DIV cycles.
// Ports: internal_clock, RST (sync, active high), clk_out.
module clk_divider #(
  parameter int DIV = 2
) (
  input  logic internal_clock,
  input  logic RST,
  output logic clk_out
);

  // DIV=1 still needs a one-bit counter
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge internal_clock) begin
    if (RST) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_serial_display.sv
// bcd_serial_display: serialises packed BCD digits onto a data/enable
// line with board and bit clocks. Ports: internal_clock, RST, VALUE_BCD,
// START in; VALUE/ENABLE/BOARD_CLOCK/DATA_CLOCK_SIGNAL, BUSY,
// FRAME_DONE, BCD_ERR out.
module bcd_serial_display
  import display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int BCLK_DIV   = 401,
  parameter int SCLK_DIV   = 2001,
  parameter int GAP_BITS   = 4*DIGITS,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic                internal_clock,
  input  logic                RST,
  input  logic [4*DIGITS-1:0] VALUE_BCD,
  input  logic                START,
  output logic                VALUE_SIGNAL,
  output logic                ENABLE_SIGNAL,
  output logic                BOARD_CLOCK_SIGNAL,
  output logic                DATA_CLOCK_SIGNAL,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                BCD_ERR
);

  localparam int NB   = 4*DIGITS;
  localparam int IW   = $clog2(NB);
  localparam int CNTW = $clog2(NB + GAP_BITS + 1);

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(NB);
  localparam logic [CNTW-1:0] GAP_END  = CNTW'(NB + GAP_BITS);

  state_t          state;
  logic [NB-1:0]   frame;
  logic [NB-1:0]   clean;
  logic            bad;
  logic [3:0]      dig;
  logic            sclk_q;
  logic            tick;
  logic [CNTW-1:0] cnt;
  logic [IW-1:0]   sel;

  clk_divider #(.DIV(BCLK_DIV)) u_bclk (
    .internal_clock (internal_clock),
    .RST            (RST),
    .clk_out        (BOARD_CLOCK_SIGNAL)
  );

  clk_divider #(.DIV(SCLK_DIV)) u_sclk (
    .internal_clock (internal_clock),
    .RST            (RST),
    .clk_out        (DATA_CLOCK_SIGNAL)
  );

  always_ff @(posedge internal_clock) begin
    if (RST) sclk_q <= 1'b0;
    else     sclk_q <= DATA_CLOCK_SIGNAL;
  end

  assign tick = DATA_CLOCK_SIGNAL & ~sclk_q;

  // blank out-of-range digits at latch time
  always_comb begin
    clean = '0;
    bad   = 1'b0;
    dig   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig              = VALUE_BCD[4*k +: 4];
      clean[4*k +: 4]  = clean_digit(dig);
      bad              = bad | (dig > BCD_MAX);
    end
  end

  // digit-ascending, MSB-first within a digit: flip low two bits
  assign sel = cnt[IW-1:0] ^ IW'(3);

  always_ff @(posedge internal_clock) begin
    if (RST) begin
      state         <= IDLE;
      frame         <= '0;
      cnt           <= '0;
      VALUE_SIGNAL  <= 1'b0;
      ENABLE_SIGNAL <= 1'b0;
      BUSY          <= 1'b0;
      FRAME_DONE    <= 1'b0;
      BCD_ERR       <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      BCD_ERR    <= 1'b0;
      unique case (state)
        IDLE: begin
          // a request coinciding with FRAME_DONE is dropped
          if (CONTINUOUS || (START && !FRAME_DONE)) begin
            state   <= ARM;
            frame   <= clean;
            BCD_ERR <= bad;
            cnt     <= '0;
            BUSY    <= 1'b1;
          end
        end
        ARM: begin
          if (tick) begin
            state         <= SHIFT;
            VALUE_SIGNAL  <= frame[sel];
            ENABLE_SIGNAL <= 1'b1;
            cnt           <= cnt + CNTW'(1);
          end
        end
        SHIFT: begin
          if (tick) begin
            if (cnt == LAST_BIT) begin
              state         <= GAP;
              VALUE_SIGNAL  <= 1'b0;
              ENABLE_SIGNAL <= 1'b0;
            end else begin
              VALUE_SIGNAL <= frame[sel];
            end
            cnt <= cnt + CNTW'(1);
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt == GAP_END) begin
              FRAME_DONE <= 1'b1;
              if (CONTINUOUS) begin
                state   <= ARM;
                frame   <= clean;
                BCD_ERR <= bad;
                cnt     <= '0;
              end else begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_display.sv
// tb_bcd_serial_display: directed bench for one-shot and continuous
// instances of the serial BCD display driver.
module tb_bcd_serial_display;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  bcd_serial_display_if #(.DIGITS(4)) if0 ();
  bcd_serial_display_if #(.DIGITS(4)) if1 ();

  bcd_serial_display #(
    .DIGITS(4), .BCLK_DIV(1), .SCLK_DIV(2),
    .GAP_BITS(16), .CONTINUOUS(1'b0)
  ) dut0 (
    .internal_clock     (clk),
    .RST                (rst0),
    .VALUE_BCD          (if0.value_bcd),
    .START              (if0.start),
    .VALUE_SIGNAL       (if0.value),
    .ENABLE_SIGNAL      (if0.enable),
    .BOARD_CLOCK_SIGNAL (if0.board_clk),
    .DATA_CLOCK_SIGNAL  (if0.data_clk),
    .BUSY               (if0.busy),
    .FRAME_DONE         (if0.frame_done),
    .BCD_ERR            (if0.bcd_err)
  );

  bcd_serial_display #(
    .DIGITS(4), .BCLK_DIV(1), .SCLK_DIV(2),
    .GAP_BITS(16), .CONTINUOUS(1'b1)
  ) dut1 (
    .internal_clock     (clk),
    .RST                (rst1),
    .VALUE_BCD          (if1.value_bcd),
    .START              (if1.start),
    .VALUE_SIGNAL       (if1.value),
    .ENABLE_SIGNAL      (if1.enable),
    .BOARD_CLOCK_SIGNAL (if1.board_clk),
    .DATA_CLOCK_SIGNAL  (if1.data_clk),
    .BUSY               (if1.busy),
    .FRAME_DONE         (if1.frame_done),
    .BCD_ERR            (if1.bcd_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed instance select
  logic sel = 1'b0;
  logic v_m, en_m, dclk_m, busy_m, done_m, err_m;

  always_comb begin
    if (sel) begin
      v_m = if1.value;  en_m = if1.enable; dclk_m = if1.data_clk;
      busy_m = if1.busy; done_m = if1.frame_done; err_m = if1.bcd_err;
    end else begin
      v_m = if0.value;  en_m = if0.enable; dclk_m = if0.data_clk;
      busy_m = if0.busy; done_m = if0.frame_done; err_m = if0.bcd_err;
    end
  end

  int   cyc = 0, done_cnt = 0, err_cnt = 0, rise_cnt = 0;
  int   en_rise_cyc = 0, en_fall_cyc = 0, done_cyc = 0;
  logic busy_at_done = 1'b0, busy_pre_done = 1'b0;
  logic en_last = 1'b0, busy_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (en_m && !en_last) begin
      en_rise_cyc = cyc;
      rise_cnt++;
    end
    if (!en_m && en_last) en_fall_cyc = cyc;
    if (done_m) begin
      done_cnt++;
      done_cyc      = cyc;
      busy_at_done  = busy_m;
      busy_pre_done = busy_last;
    end
    if (err_m) err_cnt++;
    en_last   = en_m;
    busy_last = busy_m;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_fall(output bit ok);
    logic last;
    ok   = 1'b0;
    last = dclk_m;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (last && !dclk_m) ok = 1'b1;
      last = dclk_m;
    end
  endtask

  // kind 1: START pulse on dut0, 2: new value on dut1, 3: reset dut1
  task automatic get_frame(input int poke_at, input int kind,
                           output logic [15:0] s, output int nhigh);
    bit ok;
    bit fin;
    s = '0; nhigh = 0; fin = 1'b0;
    for (int i = 0; i < 80 && !fin; i++) begin
      wait_fall(ok);
      if (!ok) begin
        check("dclk_timeout", ok, 1);
        fin = 1'b1;
      end else if (en_m) begin
        s = {s[14:0], v_m};
        nhigh++;
        if (nhigh == poke_at) begin
          if (kind == 1) begin
            if0.start = 1'b1;
            @(negedge clk);
            if0.start = 1'b0;
          end else if (kind == 2) begin
            if1.value_bcd = 16'h0002;
          end else if (kind == 3) begin
            rst1 = 1'b1;
            @(posedge clk);
            #1;
            check("rst_mid_outputs",
                  {if1.value, if1.enable, if1.board_clk, if1.data_clk,
                   if1.busy, if1.frame_done, if1.bcd_err}, 0);
            @(negedge clk);
            rst1 = 1'b0;
            fin  = 1'b1;
          end
        end
      end else if (nhigh > 0) begin
        fin = 1'b1;
      end
    end
    if (!fin) check("frame_timeout", fin, 1);
  endtask

  task automatic wait_done(input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (done_m) begin
        ok = 1'b1;
        if (poke) begin
          if0.start = 1'b1;
          @(negedge clk);
          if0.start = 1'b0;
        end
      end
    end
  endtask

  task automatic start0(input logic [15:0] v);
    @(negedge clk);
    if0.value_bcd = v;
    if0.start     = 1'b1;
    @(negedge clk);
    if0.start     = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    int nh, d0, e0, r0;
    int dr0, dr1, br0, br1, ndr, nbr;
    logic ld, lb;
    bit ok;

    rst0 = 1'b1; rst1 = 1'b1;
    if0.value_bcd = '0; if0.start = 1'b0;
    if1.value_bcd = '0; if1.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out0",
          {if0.value, if0.enable, if0.board_clk, if0.data_clk,
           if0.busy, if0.frame_done, if0.bcd_err}, 0);
    check("rst_out1",
          {if1.value, if1.enable, if1.board_clk, if1.data_clk,
           if1.busy, if1.frame_done, if1.bcd_err}, 0);
    rst0 = 1'b0;
    check("clk_at_release", {if0.board_clk, if0.data_clk}, 0);

    // divided clock periods from successive rising edges
    dr0 = 0; dr1 = 0; br0 = 0; br1 = 0; ndr = 0; nbr = 0;
    ld = 1'b0; lb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.data_clk && !ld) begin
        if (ndr == 0) dr0 = i;
        else if (ndr == 1) dr1 = i;
        ndr++;
      end
      if (if0.board_clk && !lb) begin
        if (nbr == 0) br0 = i;
        else if (nbr == 1) br1 = i;
        nbr++;
      end
      ld = if0.data_clk;
      lb = if0.board_clk;
    end
    check("dclk_period", dr1 - dr0, 4);
    check("bclk_period", br1 - br0, 2);

    // one-shot frame 1234
    @(posedge clk); d0 = done_cnt; e0 = err_cnt;
    start0(16'h1234);
    check("f1234_busy_set", if0.busy, 1);
    get_frame(0, 0, s, nh);
    check("f1234_stream", s, 16'h4321);
    check("f1234_len", nh, 16);
    wait_done(1'b0, ok);
    check("f1234_done_seen", ok, 1);
    @(posedge clk);
    check("f1234_en_high_cyc", en_fall_cyc - en_rise_cyc, 64);
    check("f1234_gap_cyc", done_cyc - en_fall_cyc, 64);
    check("f1234_busy_at_done", busy_at_done, 0);
    check("f1234_busy_before", busy_pre_done, 1);
    repeat (100) @(negedge clk);
    @(posedge clk);
    check("f1234_done_once", done_cnt - d0, 1);
    check("f1234_no_err", err_cnt - e0, 0);
    check("f1234_idle", if0.busy, 0);

    // invalid digit blanked
    @(posedge clk); d0 = done_cnt; e0 = err_cnt;
    start0(16'h9A05);
    get_frame(0, 0, s, nh);
    check("f9a05_stream", s, 16'h50F9);
    check("f9a05_len", nh, 16);
    wait_done(1'b0, ok);
    check("f9a05_done_seen", ok, 1);
    @(posedge clk);
    check("f9a05_err_once", err_cnt - e0, 1);

    // START at bit 5 and at FRAME_DONE both ignored
    repeat (10) @(negedge clk);
    @(posedge clk); d0 = done_cnt; r0 = rise_cnt;
    start0(16'h0987);
    get_frame(6, 1, s, nh);
    check("f0987_stream", s, 16'h7890);
    check("f0987_len", nh, 16);
    wait_done(1'b1, ok);
    check("f0987_done_seen", ok, 1);
    repeat (150) @(negedge clk);
    @(posedge clk);
    check("f0987_done_once", done_cnt - d0, 1);
    check("f0987_one_frame", rise_cnt - r0, 1);
    check("f0987_idle", if0.busy, 0);

    // continuous: value change mid-frame applies to next frame
    sel = 1'b1;
    if1.value_bcd = 16'h0001;
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk); d0 = done_cnt;
    get_frame(6, 2, s, nh);
    check("c_f1_stream", s, 16'h1000);
    check("c_f1_len", nh, 16);
    get_frame(0, 0, s, nh);
    check("c_f2_stream", s, 16'h2000);
    check("c_f2_len", nh, 16);
    @(posedge clk);
    check("c_done_once", done_cnt - d0, 1);
    check("c_busy_held", busy_at_done, 1);

    // reset at bit 9 aborts, then restart from bit 0
    wait_done(1'b0, ok);
    check("c_f2_done_seen", ok, 1);
    @(posedge clk); d0 = done_cnt;
    get_frame(10, 3, s, nh);
    get_frame(0, 0, s, nh);
    check("r_stream", s, 16'h2000);
    check("r_len", nh, 16);
    @(posedge clk);
    check("r_no_done", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_display.md
BCD_SERIAL_DISPLAY -- requirements
Module: bcd_serial_display

Interface
REQ-001 The block SHALL have one clock, `internal_clock`, and a synchronous active-high reset, `RST`, sampled only on the rising edge of `internal_clock`.
REQ-002 Parameter DIGITS, default 4: number of BCD digits per frame, range 1..16.
REQ-003 Parameter BCLK_DIV, default 401: `internal_clock` cycles per half-period of BOARD_CLOCK_SIGNAL.
REQ-004 Parameter SCLK_DIV, default 2001: `internal_clock` cycles per half-period of DATA_CLOCK_SIGNAL.
REQ-005 Parameter GAP_BITS, default 4*DIGITS: number of data-clock ticks in the idle gap after each frame, minimum 1.
REQ-006 Parameter CONTINUOUS, default 1: 1 = frames repeat back-to-back; 0 = one frame per START.
REQ-007 Ports SHALL be as follows (name, direction, width, meaning):
- `internal_clock`, in, 1: system clock.
- `RST`, in, 1: synchronous reset.
- `VALUE_BCD`, in, 4*DIGITS: packed digits; digit k occupies bits [4k+3:4k].
- `START`, in, 1: frame request; ignored when CONTINUOUS=1.
- `VALUE_SIGNAL`, out, 1: serial data.
- `ENABLE_SIGNAL`, out, 1: high while frame bits are valid.
- `BOARD_CLOCK_SIGNAL`, out, 1: free-running board clock.
- `DATA_CLOCK_SIGNAL`, out, 1: serial bit clock.
- `BUSY`, out, 1: high from START acceptance until FRAME_DONE.
- `FRAME_DONE`, out, 1: one-cycle pulse at the end of the gap.
- `BCD_ERR`, out, 1: one-cycle pulse when a latched digit is greater than 9.

Function
REQ-008 Each divided clock SHALL toggle when its counter reaches DIV-1; the counter then returns to 0, so the period is 2*DIV cycles. Counter width SHALL be $clog2(DIV).
REQ-009 A tick SHALL be a one-cycle pulse asserted in the cycle after DATA_CLOCK_SIGNAL goes 0->1, detected from a registered copy of that signal.
REQ-010 The FSM SHALL have states IDLE, ARM, SHIFT and GAP.
REQ-011 IDLE behaviour:
- CONTINUOUS=1: go to ARM.
- CONTINUOUS=0 and START=1: go to ARM.
REQ-012 On entry to ARM, the block SHALL latch VALUE_BCD into a frame register and set BUSY=1 in the following cycle.
REQ-013 ARM SHALL move to SHIFT on the next tick, and that tick SHALL drive bit 0.
REQ-014 SHIFT SHALL send bit index n = 0..4*DIGITS-1, one per tick: digit n/4 first from digit 0, MSB-first within each digit (frame bit 4*(n/4)+3-n%4). ENABLE_SIGNAL=1 throughout.
REQ-015 Any latched digit greater than 9 SHALL be sent as 4'hF (blank), and BCD_ERR SHALL pulse once per frame, in the latch cycle.
REQ-016 After the tick driving the last bit, the next tick SHALL enter GAP and force VALUE_SIGNAL=0 and ENABLE_SIGNAL=0 for GAP_BITS ticks.
REQ-017 On the GAP_BITS-th gap tick:
- FRAME_DONE SHALL pulse for one cycle.
- CONTINUOUS=1: go to ARM (relatch) with BUSY held at 1.
- CONTINUOUS=0: go to IDLE with BUSY=0 in the same cycle as FRAME_DONE.
REQ-018 START asserted while BUSY=1 SHALL be ignored and not queued. START in the same cycle as FRAME_DONE SHALL also be ignored.
REQ-019 VALUE_BCD changes during a frame SHALL NOT affect that frame.
REQ-020 BOARD_CLOCK_SIGNAL SHALL run in every state and SHALL be independent of the FSM.
REQ-021 The bit counter SHALL be $clog2(4*DIGITS+GAP_BITS+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-022 While RST=1, on the next edge:
- All outputs SHALL be 0.
- Both divider counters SHALL be 0.
- The FSM SHALL be in IDLE.
- The frame register and bit counter SHALL be cleared.
REQ-023 RST asserted mid-frame SHALL abort the frame with no FRAME_DONE pulse. After release, CONTINUOUS=1 SHALL restart from ARM.

Structure
REQ-024 Package `display_pkg` SHALL hold the FSM state enum, the BLANK_CODE constant (4'hF) and the BCD_MAX constant (9).
REQ-025 One sub-module, `clk_divider` (parameter DIV; ports internal_clock, RST, clk_out), SHALL be instantiated twice, once per divided clock.

Verification
REQ-026 The bench SHALL use SCLK_DIV=2, BCLK_DIV=1, DIGITS=4 and cover these directed scenarios:
- CONTINUOUS=0, VALUE_BCD=16'h1234, START pulse -> serial stream 0100 0011 0010 0001, ENABLE high for 16 ticks then low for 16 ticks, FRAME_DONE pulses exactly once, BUSY falls in the same cycle.
- Clock check -> DATA_CLOCK_SIGNAL period = 4 cycles, BOARD_CLOCK_SIGNAL period = 2 cycles, both 0 at reset release.
- VALUE_BCD=16'h9A05 -> digit 'A' sent as 1111, BCD_ERR pulses once, other digits unchanged.
- START repeated at bit 5 of a frame -> ignored; exactly one FRAME_DONE; no second frame.
- CONTINUOUS=1, VALUE_BCD changed from 16'h0001 to 16'h0002 mid-frame -> current frame sends 0001, next frame sends 0010.
- RST pulsed at bit 9 -> all outputs 0 next cycle, no FRAME_DONE; after release a full new frame starts from bit 0.
